// File: rtl/gray_fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// gray_fifo_rd_ctrl
//
// Read-side controller of a Gray-pointer asynchronous FIFO. It brings the
// write domain's Gray pointer into i_clk through a two-flop synchroniser and
// decodes it to binary. It keeps the binary and Gray read pointers and derives
// the RAM read address, empty flag, fill count, read-valid and underflow.
//
// Parameters
//   N            FIFO address width; depth is 2**N, pointers are N+1 bits
//                (the MSB is the wrap bit).
//
// Ports
//   i_clk        read-domain clock
//   i_rst        synchronous, active-high reset
//   i_wptr_G     Gray write pointer from the write domain (asynchronous)
//   i_rd_en      pop request
//   o_rd_addr    binary RAM read address (low N bits of the read pointer)
//   o_rptr_G     registered Gray read pointer, sent to the write domain
//   o_empty      registered empty flag
//   o_count      fill level seen by the read side, 0..2**N
//   o_rd_valid   one-cycle pulse: RAM data for the accepted pop is valid
//   o_underflow  one-cycle pulse: pop requested while empty
// ----------------------------------------------------------------------------
module gray_fifo_rd_ctrl #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N:0]   i_wptr_G,
    input  logic         i_rd_en,
    output logic [N-1:0] o_rd_addr,
    output logic [N:0]   o_rptr_G,
    output logic         o_empty,
    output logic [N:0]   o_count,
    output logic         o_rd_valid,
    output logic         o_underflow
);

    function automatic logic [N:0] gray_to_bin(input logic [N:0] g);
        logic [N:0] b;
        b[N] = g[N];
        for (int i = N - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [N:0] bin_to_gray(input logic [N:0] b);
        return (b >> 1) ^ b;
    endfunction

    logic [N:0] wq1_q, wq2_q;
    logic [N:0] rbin_q, rbin_d;
    logic [N:0] rgray_q, rgray_d;
    logic       empty_q, empty_d;
    logic       rd_valid_q;
    logic       underflow_q;
    logic       accept;
    logic [N:0] wbin;

    // Stage: next-state of the read pointer (pure function of registers and i_rd_en)
    always_comb begin
        accept  = i_rd_en & ~empty_q;
        rbin_d  = rbin_q + {{N{1'b0}}, accept};
        rgray_d = bin_to_gray(rbin_d);
        // Compared against the already-synchronised pointer, so empty lags
        // o_count by one cycle; this only ever errs towards "empty".
        empty_d = (rgray_d == wq2_q);
    end

    // Stage: synchroniser and read-pointer registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wq1_q       <= '0;
            wq2_q       <= '0;
            rbin_q      <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wq1_q       <= i_wptr_G;
            wq2_q       <= wq1_q;
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            empty_q     <= empty_d;
            rd_valid_q  <= accept;
            underflow_q <= i_rd_en & empty_q;
        end
    end

    // Modulo subtraction keeps the count right across pointer wrap.
    assign wbin        = gray_to_bin(wq2_q);
    assign o_count     = wbin - rbin_q;
    assign o_rd_addr   = rbin_q[N-1:0];
    assign o_rptr_G    = rgray_q;
    assign o_empty     = empty_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_gray_fifo_rd_ctrl.sv
module tb_gray_fifo_rd_ctrl;

    localparam int N = 4;
    localparam int PW = 1 << (N + 1);   // pointer modulus
    localparam int DEPTH = 1 << N;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [N:0]   i_wptr_G;
    logic         i_rd_en;
    logic [N-1:0] o_rd_addr;
    logic [N:0]   o_rptr_G;
    logic         o_empty;
    logic [N:0]   o_count;
    logic         o_rd_valid;
    logic         o_underflow;

    gray_fifo_rd_ctrl #(.N(N)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wptr_G    (i_wptr_G),
        .i_rd_en     (i_rd_en),
        .o_rd_addr   (o_rd_addr),
        .o_rptr_G    (o_rptr_G),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_rd_valid  (o_rd_valid),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit rst;
        int rptr_g;
        int addr;
        int empty;
        int count;
        int valid;
        int unf;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pointers held as plain integers (binary positions)
    int m_wq1 = 0, m_wq2 = 0, m_rd = 0;
    int m_empty = 1, m_valid = 0, m_unf = 0;
    int cur_w = 0;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % PW;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive, advance the model, queue expectation.
    task automatic step(input bit rst, input int w, input bit rd);
        exp_t e;
        int acc, nrd, old_empty;
        cur_w    = w % PW;
        i_rst    = rst;
        i_wptr_G = (N+1)'(to_gray(cur_w));
        i_rd_en  = rd;
        if (rst) begin
            m_wq1 = 0; m_wq2 = 0; m_rd = 0;
            m_empty = 1; m_valid = 0; m_unf = 0;
        end else begin
            old_empty = m_empty;
            acc       = (rd && !old_empty) ? 1 : 0;
            nrd       = (m_rd + acc) % PW;
            m_empty   = (nrd == m_wq2) ? 1 : 0;
            m_valid   = acc;
            m_unf     = (rd && old_empty) ? 1 : 0;
            m_rd      = nrd;
            m_wq2     = m_wq1;
            m_wq1     = cur_w;
        end
        e.rst    = rst;
        e.rptr_g = to_gray(m_rd);
        e.addr   = m_rd % DEPTH;
        e.empty  = m_empty;
        e.count  = (m_wq2 - m_rd + PW) % PW;
        e.valid  = m_valid;
        e.unf    = m_unf;
        exp_q.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (m_empty == 0 && k < limit) begin
            step(0, cur_w, 1);
            k++;
        end
        chk("drain_bounded", m_empty, 1);
    endtask

    // Monitor: compares DUT outputs one time unit after every active edge
    initial begin
        exp_t e;
        int prev_rptr;
        bit have_prev = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rptr_G",    int'(o_rptr_G),    e.rptr_g);
                chk("rd_addr",   int'(o_rd_addr),   e.addr);
                chk("empty",     int'(o_empty),     e.empty);
                chk("count",     int'(o_count),     e.count);
                chk("rd_valid",  int'(o_rd_valid),  e.valid);
                chk("underflow", int'(o_underflow), e.unf);
                chk("count_le_depth", (int'(o_count) <= DEPTH) ? 1 : 0, 1);
                if (have_prev && !e.rst)
                    chk("rptr_one_bit", ($countones(o_rptr_G ^ (N+1)'(prev_rptr)) <= 1) ? 1 : 0, 1);
                prev_rptr = int'(o_rptr_G);
                have_prev = 1;
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_wptr_G = '0; i_rd_en = 1'b0;
        @(negedge i_clk);

        // Reset held two cycles with a non-zero write pointer (gray 0x05)
        step(1, 6, 0);
        step(1, 6, 0);

        // Fill to 3, then drain with three pops
        step(0, 0, 0);
        repeat (4) step(0, 3, 0);
        repeat (3) step(0, 3, 1);
        repeat (2) step(0, 3, 0);

        // Underflow: single pop request while empty
        step(0, 3, 1);
        repeat (2) step(0, 3, 0);

        // Wrap: advance write pointer one per cycle through 40, popping when not empty
        for (int w = 4; w <= 40; w++) step(0, w, m_empty == 0);
        drain(20);

        // Full level: from reset, jump write pointer to 16 and pop it all out
        step(1, 0, 0);
        repeat (4) step(0, 16, 0);
        chk("full_count_model", (m_wq2 - m_rd + PW) % PW, DEPTH);
        drain(40);

        // Mid-operation reset with a pop pending at count 5
        step(1, 0, 0);
        repeat (4) step(0, 5, 0);
        step(1, 5, 1);
        repeat (4) step(0, 5, 0);
        drain(20);

        // Random traffic: writer never runs more than DEPTH ahead of the reader
        step(1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            int w;
            bit rst;
            rst = ($urandom_range(0, 63) == 0);
            w   = cur_w;
            if (rst) w = 0;
            else if ($urandom_range(0, 1) == 1 && ((cur_w + 1 - m_rd + PW) % PW) <= DEPTH)
                w = cur_w + 1;
            step(rst, w, $urandom_range(0, 2) != 0);
        end
        drain(40);

        // Let the monitor consume the last expectations, bounded
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge i_clk);
        #2;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
